// File: rtl/mem_access_queue_if.sv
// Core request, GMEM (AXI-like), CRAM and CDB signal bundle for mem_access_queue.
// Error-response signals exist only when MEM_ERR_CHK_EN is defined.
interface mem_access_queue_if #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int RSV_ID_W    = 4,
    parameter int GMEM_DATA_W = 128
);
    logic                       req_valid;
    logic                       req_ready;
    logic [RSV_ID_W-1:0]        req_rsv_id;
    logic                       req_we;
    logic [1:0]                 req_size;
    logic [ADDR_W-1:0]          req_addr;
    logic [DATA_W-1:0]          req_data;

    logic                       gm_awvalid;
    logic                       gm_awready;
    logic [ADDR_W-1:0]          gm_awaddr;
    logic                       gm_wvalid;
    logic                       gm_wready;
    logic [GMEM_DATA_W-1:0]     gm_wdata;
    logic [GMEM_DATA_W/8-1:0]   gm_wstrb;
    logic                       gm_bvalid;
    logic                       gm_bready;
    logic                       gm_arvalid;
    logic                       gm_arready;
    logic [ADDR_W-1:0]          gm_araddr;
    logic                       gm_rvalid;
    logic                       gm_rready;
    logic [GMEM_DATA_W-1:0]     gm_rdata;

    logic                       cr_arvalid;
    logic                       cr_arready;
    logic [ADDR_W-1:0]          cr_araddr;
    logic                       cr_rvalid;
    logic                       cr_rready;
    logic [DATA_W-1:0]          cr_rdata;

    logic                       cdb_valid;
    logic                       cdb_ready;
    logic [RSV_ID_W+DATA_W-1:0] cdb;
`ifdef MEM_ERR_CHK_EN
    logic [1:0]                 gm_bresp;
    logic [1:0]                 gm_rresp;
    logic [1:0]                 cr_rresp;
    logic                       err_valid;
    logic [ADDR_W-1:0]          err_addr;
`endif

    modport master (
        input  req_valid, req_rsv_id, req_we, req_size, req_addr, req_data,
        output req_ready,
        output gm_awvalid, gm_awaddr, gm_wvalid, gm_wdata, gm_wstrb, gm_bready,
        output gm_arvalid, gm_araddr, gm_rready,
        input  gm_awready, gm_wready, gm_bvalid, gm_arready, gm_rvalid, gm_rdata,
        output cr_arvalid, cr_araddr, cr_rready,
        input  cr_arready, cr_rvalid, cr_rdata,
        output cdb_valid, cdb,
        input  cdb_ready
`ifdef MEM_ERR_CHK_EN
        , input gm_bresp, gm_rresp, cr_rresp
        , output err_valid, err_addr
`endif
    );

    modport slave (
        output req_valid, req_rsv_id, req_we, req_size, req_addr, req_data,
        input  req_ready,
        input  gm_awvalid, gm_awaddr, gm_wvalid, gm_wdata, gm_wstrb, gm_bready,
        input  gm_arvalid, gm_araddr, gm_rready,
        output gm_awready, gm_wready, gm_bvalid, gm_arready, gm_rvalid, gm_rdata,
        input  cr_arvalid, cr_araddr, cr_rready,
        output cr_arready, cr_rvalid, cr_rdata,
        input  cdb_valid, cdb,
        output cdb_ready
`ifdef MEM_ERR_CHK_EN
        , output gm_bresp, gm_rresp, cr_rresp
        , input err_valid, err_addr
`endif
    );
endinterface

// File: rtl/mem_access_queue.sv
// In-order load/store unit: request FIFO, CRAM/GMEM routing, lane steering, registered CDB output.
// Optional MEM_ERR_CHK_EN adds bresp/rresp checking with err_valid/err_addr reporting.
//
// state    | meaning
// IDLE     | waiting for a queued (or arriving) request
// WR       | store address/data phases outstanding
// WR_RESP  | waiting for the GMEM write response
// RD_CR    | CRAM read: address phase, then data
// RD_GM    | GMEM read: address phase, then data
// CDB      | load result held on the CDB until accepted
module mem_access_queue #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int RSV_ID_W    = 4,
    parameter int GMEM_DATA_W = 128,
    parameter int CRAM_ADDR_W = 14,
    parameter int REQ_DEPTH   = 4
) (
    input logic                 clk,
    input logic                 nrst,
    mem_access_queue_if.master  bus
);
    localparam int STRB_W = GMEM_DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int WOFF_W = $clog2(DATA_W / 8);
    localparam int PTR_W  = $clog2(REQ_DEPTH);

    typedef struct packed {
        logic [RSV_ID_W-1:0] id;
        logic                we;
        logic [1:0]          size;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   data;
    } req_t;

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_RESP, S_RD_CR, S_RD_GM, S_CDB} state_t;

    state_t state, state_n;
    req_t   fifo_q [REQ_DEPTH];
    req_t   new_req, head, dec;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   count;
    logic full, empty, enq, pop;
    logic aw_done, w_done, ar_done;
    logic aw_hs, w_hs, ar_hs, rd_hs;
    logic [RSV_ID_W+DATA_W-1:0] cdb_q;
    logic [DATA_W-1:0] gm_lo, cr_lo, rd_data;
    logic [STRB_W-1:0] strb_base;
    logic [DATA_W-1:0] wdata_lane;

    function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a, input logic [1:0] sz);
        logic [ADDR_W-1:0] r;
        r = a;
        if (sz == 2'd1) r[0] = 1'b0;
        else if (sz != 2'd0) r[1:0] = 2'b00;
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] size_ext(input logic [DATA_W-1:0] v, input logic [1:0] sz);
        case (sz)
            2'd0:    return {{(DATA_W-8){1'b0}}, v[7:0]};
            2'd1:    return {{(DATA_W-16){1'b0}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    function automatic logic is_cram(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:CRAM_ADDR_W] == '0;
    endfunction

    always_comb begin
        new_req      = '0;
        new_req.id   = bus.req_rsv_id;
        new_req.we   = bus.req_we;
        new_req.size = bus.req_size;
        new_req.addr = align(bus.req_addr, bus.req_size);
        new_req.data = bus.req_data;
    end

    assign full  = (count == (PTR_W+1)'(REQ_DEPTH));
    assign empty = (count == '0);
    assign head  = fifo_q[rd_ptr];
    // An empty queue decodes the arriving request so a load issues the cycle after acceptance.
    assign dec   = empty ? new_req : head;
    assign enq   = bus.req_valid & bus.req_ready;
    assign pop   = ((state == S_WR_RESP) & bus.gm_bvalid) | ((state == S_CDB) & bus.cdb_ready);

    assign bus.req_ready = nrst & ~full;

    always_ff @(posedge clk) begin
        if (enq) fifo_q[wr_ptr] <= new_req;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (!empty || enq)
                           state_n = dec.we ? S_WR : (is_cram(dec.addr) ? S_RD_CR : S_RD_GM);
            S_WR:      if ((aw_done | aw_hs) & (w_done | w_hs)) state_n = S_WR_RESP;
            S_WR_RESP: if (bus.gm_bvalid) state_n = S_IDLE;
            S_RD_CR,
            S_RD_GM:   if (rd_hs) state_n = S_CDB;
            S_CDB:     if (bus.cdb_ready) state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    always_comb begin
        bus.gm_awvalid = (state == S_WR) & ~aw_done;
        bus.gm_wvalid  = (state == S_WR) & ~w_done;
        bus.gm_bready  = (state == S_WR_RESP);
        bus.gm_arvalid = (state == S_RD_GM) & ~ar_done;
        bus.gm_rready  = (state == S_RD_GM) & ar_done;
        bus.cr_arvalid = (state == S_RD_CR) & ~ar_done;
        bus.cr_rready  = (state == S_RD_CR) & ar_done;
        bus.cdb_valid  = (state == S_CDB);
    end

    assign aw_hs = bus.gm_awvalid & bus.gm_awready;
    assign w_hs  = bus.gm_wvalid & bus.gm_wready;
    assign ar_hs = (bus.gm_arvalid & bus.gm_arready) | (bus.cr_arvalid & bus.cr_arready);
    assign rd_hs = (bus.gm_rready & bus.gm_rvalid) | (bus.cr_rready & bus.cr_rvalid);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            ar_done <= 1'b0;
        end else if (state_n != state) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            ar_done <= 1'b0;
        end else begin
            aw_done <= aw_done | aw_hs;
            w_done  <= w_done | w_hs;
            ar_done <= ar_done | ar_hs;
        end
    end

    // Store lanes: data replicated at its own size so every byte lane carries it.
    always_comb begin
        case (head.size)
            2'd0:    begin wdata_lane = {(DATA_W/8){head.data[7:0]}};   strb_base = STRB_W'(1); end
            2'd1:    begin wdata_lane = {(DATA_W/16){head.data[15:0]}}; strb_base = STRB_W'(3); end
            default: begin wdata_lane = head.data; strb_base = STRB_W'({(DATA_W/8){1'b1}}); end
        endcase
    end

    assign bus.gm_awaddr = head.addr;
    assign bus.gm_araddr = head.addr;
    assign bus.cr_araddr = head.addr;
    assign bus.gm_wdata  = {(GMEM_DATA_W/DATA_W){wdata_lane}};
    assign bus.gm_wstrb  = strb_base << head.addr[OFF_W-1:0];

    assign gm_lo = DATA_W'(bus.gm_rdata >> {head.addr[OFF_W-1:0], 3'b000});
    assign cr_lo = bus.cr_rdata >> {head.addr[WOFF_W-1:0], 3'b000};

`ifdef MEM_ERR_CHK_EN
    logic rd_err, wr_err;
    logic err_valid_q;
    logic [ADDR_W-1:0] err_addr_q;

    assign rd_err  = rd_hs & ((state == S_RD_CR) ? (bus.cr_rresp != 2'b00) : (bus.gm_rresp != 2'b00));
    assign wr_err  = bus.gm_bready & bus.gm_bvalid & (bus.gm_bresp != 2'b00);
    assign rd_data = rd_err ? '0 : size_ext((state == S_RD_CR) ? cr_lo : gm_lo, head.size);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            err_valid_q <= rd_err | wr_err;
            if (rd_err | wr_err) err_addr_q <= head.addr;
        end
    end

    assign bus.err_valid = err_valid_q;
    assign bus.err_addr  = err_addr_q;
`else
    assign rd_data = size_ext((state == S_RD_CR) ? cr_lo : gm_lo, head.size);
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)      cdb_q <= '0;
        else if (rd_hs) cdb_q <= {head.id, rd_data};
    end

    assign bus.cdb = cdb_q;
endmodule

// File: tb/tb_mem_access_queue.sv
// Directed scoreboard bench for mem_access_queue with zero-wait GMEM/CRAM slave models.
module tb_mem_access_queue;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    mem_access_queue_if bus ();
    mem_access_queue dut (.clk(clk), .nrst(nrst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    int gm_ar_seen = 0;

    logic [35:0]  exp_cdb [$];
    logic [31:0]  exp_aw  [$];
    logic [143:0] exp_w   [$];
    logic [35:0]  e_cdb;
    logic [31:0]  e_aw;
    logic [143:0] e_w;

    logic [127:0] gm_line = '0;
    logic [31:0]  cr_word = '0;
    logic aw_got, w_got;

    task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // GMEM read slave
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bus.gm_rvalid <= 1'b0;
            bus.gm_rdata  <= '0;
        end else if (bus.gm_arvalid && bus.gm_arready) begin
            bus.gm_rvalid <= 1'b1;
            bus.gm_rdata  <= gm_line;
        end else if (bus.gm_rvalid && bus.gm_rready) begin
            bus.gm_rvalid <= 1'b0;
        end
    end

    // CRAM read slave
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bus.cr_rvalid <= 1'b0;
            bus.cr_rdata  <= '0;
        end else if (bus.cr_arvalid && bus.cr_arready) begin
            bus.cr_rvalid <= 1'b1;
            bus.cr_rdata  <= cr_word;
        end else if (bus.cr_rvalid && bus.cr_rready) begin
            bus.cr_rvalid <= 1'b0;
        end
    end

    // GMEM write response slave: bvalid the cycle after both aw and w are seen
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bus.gm_bvalid <= 1'b0;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
        end else begin
            if (bus.gm_bvalid && bus.gm_bready) bus.gm_bvalid <= 1'b0;
            if ((aw_got || (bus.gm_awvalid && bus.gm_awready)) &&
                (w_got || (bus.gm_wvalid && bus.gm_wready)) && !bus.gm_bvalid) begin
                bus.gm_bvalid <= 1'b1;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                aw_got <= aw_got || (bus.gm_awvalid && bus.gm_awready);
                w_got  <= w_got || (bus.gm_wvalid && bus.gm_wready);
            end
        end
    end

    // Monitor: compares each DUT output handshake against the scoreboard
    always @(negedge clk) begin
        if (nrst) begin
            if (bus.gm_arvalid) gm_ar_seen++;
            if (bus.cdb_valid && bus.cdb_ready) begin
                if (exp_cdb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL cdb_unexpected: got %0h, expected no result", bus.cdb);
                end else begin
                    e_cdb = exp_cdb.pop_front();
                    check("cdb", 144'(bus.cdb), 144'(e_cdb));
                end
            end
            if (bus.gm_awvalid && bus.gm_awready) begin
                if (exp_aw.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL aw_unexpected: got %0h, expected no write", bus.gm_awaddr);
                end else begin
                    e_aw = exp_aw.pop_front();
                    check("awaddr", 144'(bus.gm_awaddr), 144'(e_aw));
                end
            end
            if (bus.gm_wvalid && bus.gm_wready) begin
                if (exp_w.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL w_unexpected: got %0h, expected no write", bus.gm_wdata);
                end else begin
                    e_w = exp_w.pop_front();
                    check("wstrb", 144'(bus.gm_wstrb), 144'(e_w[143:128]));
                    check("wdata", 144'(bus.gm_wdata), 144'(e_w[127:0]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] id, input logic we, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] data);
        int budget = 0;
        bus.req_valid  = 1'b1;
        bus.req_rsv_id = id;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_addr   = addr;
        bus.req_data   = data;
        while (!bus.req_ready && budget < 50) begin
            tick();
            budget++;
        end
        if (!bus.req_ready) check("req_ready_timeout", 144'(bus.req_ready), 144'(1));
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic load(input logic [3:0] id, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] exp_data);
        exp_cdb.push_back({id, exp_data});
        send(id, 1'b0, size, addr, 32'h0);
    endtask

    task automatic store(input logic [3:0] id, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] e_addr,
                         input logic [15:0] e_strb, input logic [127:0] e_data);
        exp_aw.push_back(e_addr);
        exp_w.push_back({e_strb, e_data});
        send(id, 1'b1, size, addr, data);
    endtask

    task automatic drain();
        int budget = 0;
        while ((exp_cdb.size() + exp_aw.size() + exp_w.size()) != 0 && budget < 200) begin
            tick();
            budget++;
        end
        check("drain", 144'(exp_cdb.size() + exp_aw.size() + exp_w.size()), 144'(0));
        repeat (4) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0; bus.req_rsv_id = '0; bus.req_we = 1'b0;
        bus.req_size = '0; bus.req_addr = '0; bus.req_data = '0;
        bus.gm_awready = 1'b1; bus.gm_wready = 1'b1;
        bus.gm_arready = 1'b1; bus.cr_arready = 1'b1;
        bus.cdb_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 144'(bus.req_ready), 144'(0));
        check("rst_cdb_valid", 144'(bus.cdb_valid), 144'(0));
        check("rst_cdb", 144'(bus.cdb), 144'(0));
        check("rst_valids", 144'({bus.gm_awvalid, bus.gm_wvalid, bus.gm_arvalid, bus.cr_arvalid}), 144'(0));
        check("rst_readys", 144'({bus.gm_bready, bus.gm_rready, bus.cr_rready}), 144'(0));
        nrst = 1'b1;
        #1;
        check("rel_req_ready", 144'(bus.req_ready), 144'(1));
        tick();

        // 1: CRAM word load, latency
        gm_ar_seen = 0;
        cr_word = 32'hDEADBEEF;
        load(4'h1, 2'd2, 32'h0000_0100, 32'hDEADBEEF);
        check("t1_cr_arvalid_c1", 144'(bus.cr_arvalid), 144'(1));
        check("t1_cr_araddr", 144'(bus.cr_araddr), 144'(32'h100));
        tick();
        check("t1_cr_rready_c2", 144'(bus.cr_rready), 144'(1));
        check("t1_cdb_valid_c2", 144'(bus.cdb_valid), 144'(0));
        tick();
        check("t1_cdb_valid_c3", 144'(bus.cdb_valid), 144'(1));
        drain();
        check("t1_gm_ar_seen", 144'(gm_ar_seen), 144'(0));

        // 2: GMEM byte store
        store(4'h2, 2'd0, 32'h0001_0007, 32'h0000_00A5, 32'h0001_0007, 16'h0080, {16{8'hA5}});
        check("t2_awvalid", 144'(bus.gm_awvalid), 144'(1));
        tick();
        check("t2_bready", 144'(bus.gm_bready), 144'(1));
        tick();
        check("t2_bready_after_pop", 144'(bus.gm_bready), 144'(0));
        drain();

        // 3: GMEM half load, misaligned address
        gm_line = 128'hFFFFFFFF_1234FFFF_FFFFFFFF_FFFFFFFF;
        load(4'h3, 2'd1, 32'h0001_000B, 32'h0000_1234);
        check("t3_araddr", 144'(bus.gm_araddr), 144'(32'h0001_000A));
        drain();

        // 4: fill FIFO while aw is stalled; order preserved
        bus.gm_awready = 1'b0;
        store(4'h4, 2'd0 + 2'd2, 32'h0002_0000, 32'h1122_3344, 32'h0002_0000, 16'h000F, {4{32'h1122_3344}});
        store(4'h5, 2'd1, 32'h0002_0006, 32'h7777_BEEF, 32'h0002_0006, 16'h00C0, {8{16'hBEEF}});
        store(4'h6, 2'd0, 32'h0002_000F, 32'h0000_005A, 32'h0002_000F, 16'h8000, {16{8'h5A}});
        store(4'h7, 2'd3, 32'h0002_0013, 32'hCAFE_F00D, 32'h0002_0010, 16'h000F, {4{32'hCAFE_F00D}});
        check("t4_full_ready", 144'(bus.req_ready), 144'(0));
        repeat (3) tick();
        check("t4_full_ready_held", 144'(bus.req_ready), 144'(0));
        bus.gm_awready = 1'b1;
        store(4'h8, 2'd1, 32'h0002_0021, 32'h9999_ABCD, 32'h0002_0020, 16'h0003, {8{16'hABCD}});
        drain();

        // 5: CDB back-pressure
        bus.cdb_ready = 1'b0;
        cr_word = 32'h1122_3344;
        gm_line = 128'h00000000_00000000_89ABCDEF_00000000;
        load(4'h5, 2'd0, 32'h0000_0206, 32'h0000_0022);
        load(4'h6, 2'd2, 32'h0003_0004, 32'h89AB_CDEF);
        begin
            int budget = 0;
            while (!bus.cdb_valid && budget < 20) begin
                tick();
                budget++;
            end
        end
        check("t5_cdb_valid", 144'(bus.cdb_valid), 144'(1));
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_cdb_held_valid", 144'(bus.cdb_valid), 144'(1));
            check("t5_cdb_stable", 144'(bus.cdb), 144'({4'h5, 32'h0000_0022}));
            check("t5_arvalid_blocked", 144'(bus.gm_arvalid), 144'(0));
        end
        bus.cdb_ready = 1'b1;
        tick();
        check("t5_arvalid_idle", 144'(bus.gm_arvalid), 144'(0));
        tick();
        check("t5_arvalid_next", 144'(bus.gm_arvalid), 144'(1));
        check("t5_araddr_next", 144'(bus.gm_araddr), 144'(32'h0003_0004));
        drain();

        // 6: reset during WR
        bus.gm_awready = 1'b0;
        bus.gm_wready  = 1'b0;
        send(4'h7, 1'b1, 2'd2, 32'h0002_0040, 32'h5555_5555);
        check("t6_awvalid_pre", 144'(bus.gm_awvalid), 144'(1));
        #2;
        nrst = 1'b0;
        #1;
        check("t6_rst_valids", 144'({bus.gm_awvalid, bus.gm_wvalid, bus.gm_arvalid, bus.cr_arvalid}), 144'(0));
        check("t6_rst_req_ready", 144'(bus.req_ready), 144'(0));
        check("t6_rst_cdb", 144'({bus.cdb_valid, bus.cdb}), 144'(0));
        tick();
        tick();
        nrst = 1'b1;
        #1;
        check("t6_rel_req_ready", 144'(bus.req_ready), 144'(1));
        bus.gm_awready = 1'b1;
        bus.gm_wready  = 1'b1;
        tick();
        check("t6_idle_awvalid", 144'(bus.gm_awvalid), 144'(0));
        cr_word = 32'h0BAD_F00D;
        load(4'h8, 2'd2, 32'h0000_0040, 32'h0BAD_F00D);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
